regfile_wb_sched: RTL

- Write-back scheduler for the RV32I 32x32 register file's single write port (WE3/A3/WD3).
- Round-robin arbitrates two write-back requesters, the ALU/execute path (req0) and the load unit (req1), onto that port.
- Keeps a per-register pending-write scoreboard, set at issue, so decode can stall RAW/WAW hazards on rs1/rs2/rd.
- Sits between issue/execute/load units and register_file.

---
 rtl/regfile_wb_sched_pkg.sv | 17 +
 rtl/regfile_wb_sched_if.sv | 62 ++++++
 rtl/regfile_wb_sched_rr_arb2.sv | 28 ++
 rtl/regfile_wb_sched.sv | 92 +++++++++
 4 files changed

// File: rtl/regfile_wb_sched_pkg.sv
// rtl/regfile_wb_sched_pkg.sv - shared constants and types for the register-file write-back scheduler
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xdata_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  function automatic logic is_x0(input reg_addr_t a);
    return a == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_wb_sched_if.sv
// rtl/regfile_wb_sched_if.sv - issue, write-back request, hazard query and write-port bundle
// Optional forwarding outputs exist only when REGFILE_WB_BYPASS_EN is defined.
interface regfile_wb_sched_if;
  import regfile_pkg::*;

  logic      issue_valid;
  reg_addr_t issue_rd;
  logic      issue_ready;

  logic      req0_valid;
  reg_addr_t req0_rd;
  xdata_t    req0_data;
  logic      req0_ready;

  logic      req1_valid;
  reg_addr_t req1_rd;
  xdata_t    req1_data;
  logic      req1_ready;

  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  logic      rs1_busy;
  logic      rs2_busy;

  logic      rf_we;
  reg_addr_t rf_waddr;
  xdata_t    rf_wdata;

`ifdef REGFILE_WB_BYPASS_EN
  logic      rs1_fwd;
  logic      rs2_fwd;
  xdata_t    fwd_data1;
  xdata_t    fwd_data2;
`endif

  modport slave (
    input  issue_valid, issue_rd,
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    input  rs1_addr, rs2_addr,
    output issue_ready, req0_ready, req1_ready,
    output rs1_busy, rs2_busy,
    output rf_we, rf_waddr, rf_wdata
`ifdef REGFILE_WB_BYPASS_EN
    , output rs1_fwd, rs2_fwd, fwd_data1, fwd_data2
`endif
  );

  modport master (
    output issue_valid, issue_rd,
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    output rs1_addr, rs2_addr,
    input  issue_ready, req0_ready, req1_ready,
    input  rs1_busy, rs2_busy,
    input  rf_we, rf_waddr, rf_wdata
`ifdef REGFILE_WB_BYPASS_EN
    , input rs1_fwd, rs2_fwd, fwd_data1, fwd_data2
`endif
  );

endinterface

// File: rtl/regfile_wb_sched_rr_arb2.sv
// rtl/regfile_wb_sched_rr_arb2.sv - two-way round-robin arbiter, pointer 0 favours requester 0
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  logic r_ptr;
  logic [1:0] w_grant;

  always_comb begin
    w_grant = i_valid;
    if (i_valid == 2'b11)
      w_grant = r_ptr ? 2'b10 : 2'b01;
  end

  assign o_grant = w_grant;

  // After a grant the other requester becomes favoured; idle cycles hold the pointer.
  always_ff @(posedge clk) begin
    if (!rst)
      r_ptr <= 1'b0;
    else if (|w_grant)
      r_ptr <= w_grant[0];
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - write-back scheduler and pending-write scoreboard for the RV32I register file
// Define REGFILE_WB_BYPASS_EN to forward the in-flight write to the rs1/rs2 operands.
module regfile_wb_sched
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  regfile_wb_sched_if.slave bus
);

  logic [1:0] w_grant;
  reg_addr_t  w_sel_rd;
  xdata_t     w_sel_data;
  logic       w_issue_fire;
  logic [NREG-1:0] w_pend_next;

  logic            r_rf_we;
  reg_addr_t       r_rf_waddr;
  xdata_t          r_rf_wdata;
  logic [NREG-1:0] r_pend;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_valid ({bus.req1_valid, bus.req0_valid}),
    .o_grant (w_grant)
  );

  assign bus.req0_ready = w_grant[0];
  assign bus.req1_ready = w_grant[1];

  assign w_sel_rd   = w_grant[1] ? bus.req1_rd   : bus.req0_rd;
  assign w_sel_data = w_grant[1] ? bus.req1_data : bus.req0_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= REG_ZERO;
      r_rf_wdata <= '0;
    end else if (|w_grant) begin
      r_rf_we    <= !is_x0(w_sel_rd);
      r_rf_waddr <= w_sel_rd;
      r_rf_wdata <= w_sel_data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign bus.rf_we    = r_rf_we;
  assign bus.rf_waddr = r_rf_waddr;
  assign bus.rf_wdata = r_rf_wdata;

  // A landing write to the same register frees the slot for a new issue in the same cycle.
  assign bus.issue_ready = !r_pend[bus.issue_rd] || (r_rf_we && r_rf_waddr == bus.issue_rd);
  assign w_issue_fire    = bus.issue_valid && bus.issue_ready;

  // Clear first, then set, so a same-edge set on the same register wins.
  always_comb begin
    w_pend_next = r_pend;
    if (r_rf_we)
      w_pend_next[r_rf_waddr] = 1'b0;
    if (w_issue_fire && !is_x0(bus.issue_rd))
      w_pend_next[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      r_pend <= '0;
    else
      r_pend <= w_pend_next;
  end

`ifdef REGFILE_WB_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;

  assign w_fwd1 = r_rf_we && r_rf_waddr == bus.rs1_addr && !is_x0(bus.rs1_addr);
  assign w_fwd2 = r_rf_we && r_rf_waddr == bus.rs2_addr && !is_x0(bus.rs2_addr);

  assign bus.rs1_fwd   = w_fwd1;
  assign bus.rs2_fwd   = w_fwd2;
  assign bus.fwd_data1 = r_rf_wdata;
  assign bus.fwd_data2 = r_rf_wdata;

  assign bus.rs1_busy = r_pend[bus.rs1_addr] && !is_x0(bus.rs1_addr) && !w_fwd1;
  assign bus.rs2_busy = r_pend[bus.rs2_addr] && !is_x0(bus.rs2_addr) && !w_fwd2;
`else
  assign bus.rs1_busy = r_pend[bus.rs1_addr] && !is_x0(bus.rs1_addr);
  assign bus.rs2_busy = r_pend[bus.rs2_addr] && !is_x0(bus.rs2_addr);
`endif

endmodule
